// File: rtl/seq_div_signed_pkg.sv
// Shared types and sizing helpers for the sequential signed/unsigned divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam int DEF_M = 16;
    localparam int DEF_N = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DEF_M);

endpackage

// File: rtl/seq_div_signed_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_div_signed_if #(
    parameter int m = 16,
    parameter int n = 16
);
    logic         start;
    logic         sgn;
    logic [m-1:0] a;
    logic [n-1:0] b;
    logic         busy;
    logic         done;
    logic [m-1:0] q;
    logic [n-1:0] r;
    logic         dz;

    modport master (
        output start, sgn, a, b,
        input  busy, done, q, r, dz
    );

    modport slave (
        input  start, sgn, a, b,
        output busy, done, q, r, dz
    );
endinterface

// File: rtl/seq_div_signed_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int n = 16
) (
    input  logic [n:0]   rem,
    input  logic         din,
    input  logic [n-1:0] dvsr,
    output logic [n:0]   rem_next,
    output logic         qbit
);
    logic [n:0]   shifted;
    logic [n+1:0] diff;
    logic         unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit is never set
    // going in; the extra bit only holds the shifted-out carry.
    assign unused_rem_msb = rem[n];

    always_comb begin
        shifted  = {rem[n-1:0], din};
        diff     = {1'b0, shifted} - {2'b00, dvsr};
        qbit     = ~diff[n+1];
        rem_next = qbit ? diff[n:0] : shifted;
    end
endmodule

// File: rtl/seq_div_signed.sv
// Radix-2 restoring divider, one quotient bit per clock, with signed fix-up and divide-by-zero path.
module seq_div_signed
    import div_pkg::*;
#(
    parameter int m = DEF_M,
    parameter int n = DEF_N
) (
    input  logic           clk,
    input  logic           rst,
    seq_div_signed_if.slave bus
);
    localparam int CW = cnt_width(m);

    state_t        state_reg;
    logic          sa_reg, sb_reg, zero_reg;
    logic [m-1:0]  dvd_reg, quot_reg, q_reg;
    logic [n-1:0]  dvsr_reg, r_reg;
    logic [n:0]    rem_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg, done_reg, dz_reg;

    logic          sa_in, sb_in;
    logic [m-1:0]  a_mag;
    logic [n-1:0]  b_mag;
    logic [n:0]    rem_next;
    logic          qbit;

    always_comb begin
        sa_in = bus.sgn & bus.a[m-1];
        sb_in = bus.sgn & bus.b[n-1];
        a_mag = sa_in ? -bus.a : bus.a;
        b_mag = sb_in ? -bus.b : bus.b;
    end

    div_step #(.n(n)) u_step (
        .rem      (rem_reg),
        .din      (dvd_reg[m-1]),
        .dvsr     (dvsr_reg),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            zero_reg  <= 1'b0;
            dvd_reg   <= '0;
            quot_reg  <= '0;
            dvsr_reg  <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        busy_reg <= 1'b1;
                        sa_reg   <= sa_in;
                        sb_reg   <= sb_in;
                        rem_reg  <= '0;
                        quot_reg <= '0;
                        cnt_reg  <= CW'(m - 1);
                        dvsr_reg <= b_mag;
                        if (bus.b == '0) begin
                            // Keep the raw dividend: its low bits become the remainder.
                            zero_reg  <= 1'b1;
                            dvd_reg   <= bus.a;
                            state_reg <= FIX;
                        end else begin
                            zero_reg  <= 1'b0;
                            dvd_reg   <= a_mag;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg  <= rem_next;
                    dvd_reg  <= {dvd_reg[m-2:0], 1'b0};
                    quot_reg <= {quot_reg[m-2:0], qbit};
                    if (cnt_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                FIX: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                    if (zero_reg) begin
                        q_reg  <= '1;
                        r_reg  <= dvd_reg[n-1:0];
                        dz_reg <= 1'b1;
                    end else begin
                        // Truncating division: remainder follows the dividend's sign.
                        q_reg  <= (sa_reg ^ sb_reg) ? -quot_reg : quot_reg;
                        r_reg  <= sa_reg ? -rem_reg[n-1:0] : rem_reg[n-1:0];
                        dz_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.q    = q_reg;
    assign bus.r    = r_reg;
    assign bus.dz   = dz_reg;
endmodule

// File: tb/tb_seq_div_signed.sv
// Directed bench for seq_div_signed: latency, sign handling, zero divisor, abort, round trips.
module tb_seq_div_signed;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    int   pulses;

    seq_div_signed_if #(.m(16), .n(16)) bus ();

    seq_div_signed #(.m(16), .n(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge; the next edge (E0) accepts the request.
    task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
        bus.sgn   = s;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'hxxxx;
        bus.b     = 16'hxxxx;
    endtask

    task automatic wait_done(output int n_cyc);
        n_cyc = 0;
        while (bus.done !== 1'b1 && n_cyc < 40) begin
            @(posedge clk);
            #1;
            n_cyc++;
        end
        if (bus.done !== 1'b1) n_cyc = 99;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                          input logic [15:0] b, input int exp_lat,
                          input logic [15:0] eq, input logic [15:0] er, input logic edz);
        int l;
        launch(s, a, b);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(l);
        $display("op %s sgn=%0d a=%h b=%h q=%h r=%h dz=%0d lat=%0d",
                 tag, s, a, b, bus.q, bus.r, bus.dz, l);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_q"}, {16'd0, bus.q}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, bus.r}, {16'd0, er});
        chk({tag, "_dz"}, {31'd0, bus.dz}, {31'd0, edz});
    endtask

    task automatic rand_op(input logic s);
        logic [15:0] a, b;
        int ai, bi, qi, ri, l;
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        if (b == 16'd0) b = 16'd3;
        if (s && a == 16'h8000 && b == 16'hFFFF) b = 16'd2;
        launch(s, a, b);
        wait_done(l);
        chk("rnd_lat", l, 17);
        if (s) begin
            ai = int'($signed(a)); bi = int'($signed(b));
            qi = int'($signed(bus.q)); ri = int'($signed(bus.r));
        end else begin
            ai = int'(a); bi = int'(b); qi = int'(bus.q); ri = int'(bus.r);
        end
        $display("rnd sgn=%0d a=%0d b=%0d q=%0d r=%0d", s, ai, bi, qi, ri);
        chk("rnd_identity", qi * bi + ri, ai);
        chk("rnd_rem_mag", {31'd0, ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi))}, 32'd1);
        chk("rnd_rem_sign", {31'd0, (ri == 0 || ((ri < 0) == (ai < 0)))}, 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = 16'd0;
        bus.b     = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dz", {31'd0, bus.dz}, 32'd0);
        chk("rst_q", {16'd0, bus.q}, 32'd0);
        chk("rst_r", {16'd0, bus.r}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("u100_7",    1'b0, 16'd100,  16'd7,    17, 16'd14,   16'd2,    1'b0);
        run_op("s-100_7",   1'b1, 16'hFF9C, 16'd7,    17, 16'hFFF2, 16'hFFFE, 1'b0);
        run_op("s100_-7",   1'b1, 16'd100,  16'hFFF9, 17, 16'hFFF2, 16'd2,    1'b0);
        run_op("s_ovf",     1'b1, 16'h8000, 16'hFFFF, 17, 16'h8000, 16'd0,    1'b0);
        run_op("u_ffff_1",  1'b0, 16'hFFFF, 16'd1,    17, 16'hFFFF, 16'd0,    1'b0);
        run_op("dz",        1'b0, 16'd5,    16'd0,    1,  16'hFFFF, 16'd5,    1'b1);
        // Round trips: 123*45=5535, -57*33=-1881 (0xF8A7), -57*-33=1881 (0x0759)
        run_op("rt_u",      1'b0, 16'd5535, 16'd45,   17, 16'd123,  16'd0,    1'b0);
        run_op("rt_s1",     1'b1, 16'hF8A7, 16'd33,   17, 16'hFFC7, 16'd0,    1'b0);
        run_op("rt_s2",     1'b1, 16'h0759, 16'hFFDF, 17, 16'hFFC7, 16'd0,    1'b0);

        // A second start mid-CALC must be ignored.
        launch(1'b0, 16'd100, 16'd7);
        repeat (5) begin @(posedge clk); #1; end
        bus.a = 16'd9; bus.b = 16'd2; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        lat = (lat == 99) ? 99 : lat + 6;
        $display("op ignore_start q=%h r=%h lat=%0d", bus.q, bus.r, lat);
        chk("ign_lat", lat, 17);
        chk("ign_q", {16'd0, bus.q}, 32'd14);
        chk("ign_r", {16'd0, bus.r}, 32'd2);

        // Back-to-back: start raised during the done cycle.
        launch(1'b0, 16'd200, 16'd9);
        chk("b2b_done_pulse", {31'd0, bus.done}, 32'd0);
        chk("b2b_hold_q", {16'd0, bus.q}, 32'd14);
        wait_done(lat);
        $display("op b2b q=%h r=%h lat=%0d", bus.q, bus.r, lat);
        chk("b2b_lat", lat, 17);
        chk("b2b_q", {16'd0, bus.q}, 32'd22);
        chk("b2b_r", {16'd0, bus.r}, 32'd2);

        // Asynchronous abort during cycle 8 of an operation.
        launch(1'b0, 16'd1000, 16'd3);
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_q", {16'd0, bus.q}, 32'd0);
        chk("abort_r", {16'd0, bus.r}, 32'd0);
        #2;
        rst = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        $display("op abort done_pulses=%0d", pulses);
        chk("abort_no_done", pulses, 0);
        run_op("post_abort", 1'b1, 16'hFF9C, 16'hFFF9, 17, 16'd14, 16'hFFFE, 1'b0);

        for (int i = 0; i < 8; i++) rand_op(1'b0);
        for (int i = 0; i < 8; i++) rand_op(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_div_signed.md
# seq_div_signed

Sequential radix-2 divider, the inverse of the team's combinational signed row multiplier: it recovers quotient and remainder from a product-width dividend and a multiplier-width divisor, one quotient bit per clock. It sits alongside the multiplier in the arithmetic-unit library. The testbench closes a multiply/divide round trip (p = a*b, then p/b = a) in both signed and unsigned modes.

## Interface
- m, 16: dividend and quotient width; must satisfy m >= n
- n, 16: divisor and remainder width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  m  dividend; sampled with start
- b  input  n  divisor; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; q, r, dz valid
- q  output  m  quotient, held until the next done
- r  output  n  remainder, held until the next done
- dz  output  1  divide-by-zero flag, qualified by done

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, b != 0:
  - Latch sign flags sa = sgn & a[m-1] and sb = sgn & b[n-1].
  - Latch magnitudes |a| (m bits) and |b| (n bits). A magnitude is taken only when its sign flag is set.
  - Clear the partial remainder (n+1 bits). Load the step counter with m-1. Go to CALC.
- IDLE, start=1, b == 0: go to FIX with the zero flag set. No CALC steps are run.
- CALC, one restoring step per clock:
  - Shift the partial remainder left by one and insert the next dividend bit (MSB first).
  - Trial-subtract |b|. If the result is non-negative, keep it and shift 1 into the quotient register. Otherwise keep the shifted value and shift 0 in.
  - When the counter reaches 0, go to FIX. Otherwise decrement the counter.
- FIX, normal case:
  - q = (sa ^ sb) ? -quot : quot.
  - r = sa ? -rem : rem. The remainder takes the sign of the dividend (truncating division).
  - dz = 0, done = 1. Go to IDLE.
- FIX, zero divisor: q = all ones, r = a[n-1:0], dz = 1, done = 1. Go to IDLE.
- Overflow is not special-cased. For signed most-negative / -1, the natural result is q = most-negative, r = 0. Widths: internal quotient is m bits; remainder magnitude is at most n bits.
- start while busy=1 is ignored. No queueing, no error.

## Timing
- Reset values:
  - State IDLE.
  - busy = 0, done = 0, dz = 0.
  - q = 0, r = 0.
  - All internal registers 0.
- Let E0 be the edge that accepts start.
  - busy rises after E0.
  - CALC occupies edges E1 through Em.
  - FIX registers the results at E(m+1). done is high for exactly the cycle after E(m+1), and busy falls at the same edge.
  - Latency is m+1 cycles; 17 for the defaults.
- Divide by zero: results and done are registered at E1, a latency of 1 cycle.
- Back-to-back: start asserted during the done cycle is accepted, because the FSM is already in IDLE. The new q and r overwrite the old ones only at the next done.
- Operand inputs are don't-care after E0.
- rst asserted mid-operation: all state and outputs return to reset values immediately. No done is produced for the aborted operation.

## Structure
- Shared package div_pkg holds:
  - The state enum {IDLE, CALC, FIX}.
  - The counter-width constant $clog2(m).
- Sub-module div_step: combinational, one restoring step. Inputs: partial remainder, incoming dividend bit, |b|. Outputs: next remainder and quotient bit.
- The top level holds the FSM, operand and result registers, and the sign fix-up.

## Test plan
- Unsigned, a=100, b=7 -> done 17 cycles after start, q=14, r=2, dz=0.
- Signed, a=0xFF9C (-100), b=7 -> q=0xFFF2 (-14), r=0xFFFE (-2). Signed, a=100, b=0xFFF9 (-7) -> q=0xFFF2, r=2.
- Signed, a=0x8000, b=0xFFFF -> q=0x8000, r=0. Unsigned, a=0xFFFF, b=1 -> q=0xFFFF, r=0.
- a=5, b=0 -> done 1 cycle after start, dz=1, q=0xFFFF, r=5.
- start pulsed mid-CALC with different operands -> ignored; the first result arrives unchanged. start held during the done cycle -> second result is done 17 cycles later.
- rst asserted at cycle 8 of an operation -> busy=0, done never pulses, q=r=0. A new operation afterwards completes correctly.
- Random sweep, both modes -> q*b + r == a, |r| < |b|, and r has the sign of a.
